// File: rtl/replica_pkg.sv
// Shared types for the replica-exchange ring: ordering word layout, ordering
// depth and the state encoding of the ordering shift node.
package replica_pkg;

  localparam int city_div        = 16;
  localparam int city_div_log    = 4;
  localparam int city_w          = 7;
  localparam int cities_per_word = 8;

  typedef logic [cities_per_word-1:0][city_w-1:0] replica_data_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_IN = 2'd2,
    ST_COMMIT  = 2'd3
  } ordering_shift_state_t;

endpackage

// File: rtl/ordering_bank_ram.sv
// Two-bank ordering store: one write port, registered send and local read ports.
// The array itself is not reset; only the read registers are.
module ordering_bank_ram
  import replica_pkg::*;
#(
  parameter int DEPTH = city_div,
  parameter int AW    = city_div_log
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  replica_data_t wr_data,
  input  logic          snd_en,
  input  logic          snd_bank,
  input  logic [AW-1:0] snd_addr,
  output replica_data_t snd_data,
  input  logic          loc_bank,
  input  logic [AW-1:0] loc_addr,
  output replica_data_t loc_data
);

  replica_data_t mem [0:1][0:DEPTH-1];
  replica_data_t snd_d, snd_q;
  replica_data_t loc_d, loc_q;

  // Array write, no reset on the storage
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Read muxing; the send port reads zero when idle so out_data rests at 0
  always_comb begin
    loc_d = mem[loc_bank][loc_addr];
    if (snd_en) begin
      snd_d = mem[snd_bank][snd_addr];
    end else begin
      snd_d = '0;
    end
  end

  // Read data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snd_q <= '0;
      loc_q <= '0;
    end else begin
      snd_q <= snd_d;
      loc_q <= loc_d;
    end
  end

  assign snd_data = snd_q;
  assign loc_data = loc_q;

endmodule

// File: rtl/ordering_shift_node.sv
// Per-replica ordering store: streams the committed ordering out on each
// exchange, captures the incoming one into the shadow bank and commits it.
module ordering_shift_node
  import replica_pkg::*;
#(
  parameter int CITY_DIV     = city_div,
  parameter int CITY_DIV_LOG = city_div_log
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    exchange_shift,
  input  logic                    exchange_keep,
  input  logic                    in_valid,
  input  replica_data_t           in_data,
  output logic                    out_valid,
  output replica_data_t           out_data,
  input  logic [CITY_DIV_LOG-1:0] rd_addr,
  output replica_data_t           rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err_overrun,
  output logic                    err_collision
);

  localparam logic [CITY_DIV_LOG:0]   CNT_FULL = (CITY_DIV_LOG+1)'(CITY_DIV);
  localparam logic [CITY_DIV_LOG:0]   CNT_ONE  = (CITY_DIV_LOG+1)'(1);
  localparam logic [CITY_DIV_LOG-1:0] IDX_LAST = CITY_DIV_LOG'(CITY_DIV - 1);
  localparam logic [CITY_DIV_LOG-1:0] IDX_ONE  = CITY_DIV_LOG'(1);

  ordering_shift_state_t   state_q, state_d;
  logic                    keep_q, keep_d;
  logic                    act_sel_q, act_sel_d;
  logic [CITY_DIV_LOG-1:0] idx_q, idx_d;
  logic [CITY_DIV_LOG:0]   cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_overrun_q, err_overrun_d;
  logic                    err_collision_q, err_collision_d;

  logic                    start_s;
  logic [CITY_DIV_LOG:0]   cnt_base_s;
  logic                    wr_en_s;
  logic                    snd_en_s;
  logic [CITY_DIV_LOG-1:0] snd_addr_s;

  // Exchange sequencing and commit
  always_comb begin
    state_d         = state_q;
    keep_d          = keep_q;
    act_sel_d       = act_sel_q;
    idx_d           = idx_q;
    start_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exchange_shift) begin
          start_s = 1'b1;
          keep_d  = exchange_keep;
          idx_d   = '0;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        idx_d = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          if (keep_q) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_FULL) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_WAIT_IN;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_IN: begin
        if (cnt_q == CNT_FULL) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_WAIT_IN;
        end
      end
      ST_COMMIT: begin
        act_sel_d = ~act_sel_q;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (exchange_shift && (state_q != ST_IDLE)) begin
      err_collision_d = 1'b1;
    end else begin
      err_collision_d = err_collision_q;
    end
  end

  // Shadow capture; an accepted shift restarts the count before this cycle's word
  always_comb begin
    if (start_s) begin
      cnt_base_s = '0;
    end else begin
      cnt_base_s = cnt_q;
    end
    cnt_d         = cnt_base_s;
    wr_en_s       = 1'b0;
    err_overrun_d = err_overrun_q;
    if (in_valid) begin
      if (cnt_base_s == CNT_FULL) begin
        err_overrun_d = 1'b1;
      end else begin
        wr_en_s = 1'b1;
        cnt_d   = cnt_base_s + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_base_s;
    end
  end

  // Send read addressing runs one word ahead of the registered out_data
  always_comb begin
    snd_en_s    = (state_d == ST_SEND);
    out_valid_d = (state_d == ST_SEND);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    if (state_q == ST_SEND) begin
      snd_addr_s = idx_q + IDX_ONE;
    end else begin
      snd_addr_s = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      keep_q          <= 1'b0;
      act_sel_q       <= 1'b0;
      idx_q           <= '0;
      cnt_q           <= '0;
      out_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_overrun_q   <= 1'b0;
      err_collision_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      keep_q          <= keep_d;
      act_sel_q       <= act_sel_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      out_valid_q     <= out_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_overrun_q   <= err_overrun_d;
      err_collision_q <= err_collision_d;
    end
  end

  ordering_bank_ram #(
    .DEPTH (CITY_DIV),
    .AW    (CITY_DIV_LOG)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en_s),
    .wr_bank  (~act_sel_q),
    .wr_addr  (cnt_base_s[CITY_DIV_LOG-1:0]),
    .wr_data  (in_data),
    .snd_en   (snd_en_s),
    .snd_bank (act_sel_q),
    .snd_addr (snd_addr_s),
    .snd_data (out_data),
    .loc_bank (act_sel_q),
    .loc_addr (rd_addr),
    .loc_data (rd_data)
  );

  assign out_valid     = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_overrun   = err_overrun_q;
  assign err_collision = err_collision_q;

endmodule

// File: tb/tb_ordering_shift_node.sv
// Scoreboard bench for ordering_shift_node with a 4-word ordering: directed
// exchanges push expected send words; a negedge monitor pops and compares.
module tb_ordering_shift_node;
  import replica_pkg::*;

  localparam int CD = 4;
  localparam int CL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          exchange_shift;
  logic          exchange_keep;
  logic          in_valid;
  replica_data_t in_data;
  logic          out_valid;
  replica_data_t out_data;
  logic [CL-1:0] rd_addr;
  replica_data_t rd_data;
  logic          busy;
  logic          done;
  logic          err_overrun;
  logic          err_collision;

  typedef struct packed {
    logic          care;
    replica_data_t d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   ov_cnt   = 0;
  int   done_cnt = 0;

  ordering_shift_node #(.CITY_DIV(CD), .CITY_DIV_LOG(CL)) dut (
    .clk            (clk),
    .reset          (reset),
    .exchange_shift (exchange_shift),
    .exchange_keep  (exchange_keep),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .busy           (busy),
    .done           (done),
    .err_overrun    (err_overrun),
    .err_collision  (err_collision)
  );

  always #5 clk = ~clk;

  function automatic replica_data_t mk(input logic [6:0] v);
    replica_data_t r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic care, input replica_data_t d);
    exp_t e;
    e.care = care;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented word is checked against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid) begin
      ov_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: got %h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        if (e.care) chk("out_data", out_data, e.d);
      end
    end
    if (reset && done) done_cnt++;
  end

  task automatic run_keep(input string nm, input replica_data_t w0, input replica_data_t w1,
                          input replica_data_t w2, input replica_data_t w3);
    ov_cnt = 0;
    push(1'b1, w0); push(1'b1, w1); push(1'b1, w2); push(1'b1, w3);
    exchange_shift = 1'b1; exchange_keep = 1'b1;
    cyc(1);
    exchange_shift = 1'b0; exchange_keep = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    cyc(3);
    chk({nm, "_done_early"}, done, 0);
    cyc(1);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_ov_cnt"}, ov_cnt, 4);
  endtask

  initial begin
    int done_snap;
    reset = 1'b0; exchange_shift = 1'b0; exchange_keep = 1'b0;
    in_valid = 1'b0; in_data = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_overrun", err_overrun, 0);
    chk("rst_err_collision", err_collision, 0);
    reset = 1'b1;
    cyc(1);

    // Load: bank 0 is uninitialised, words arrive +3..+6, commit into bank 1
    ov_cnt = 0;
    for (int i = 0; i < CD; i++) push(1'b0, '0);
    exchange_shift = 1'b1;
    cyc(1);
    exchange_shift = 1'b0;
    chk("load_busy", busy, 1);
    cyc(2);
    in_valid = 1'b1; in_data = mk(7'h11); cyc(1);
    in_data = mk(7'h22); cyc(1);
    in_data = mk(7'h33); cyc(1);
    chk("load_out_valid_after", out_valid, 0);
    in_data = mk(7'h44); cyc(1);
    in_valid = 1'b0;
    cyc(1);
    chk("load_commit_done", done, 0);
    chk("load_commit_busy", busy, 1);
    cyc(1);
    chk("load_done", done, 1);
    chk("load_busy_end", busy, 0);
    chk("load_ov_cnt", ov_cnt, 4);
    rd_addr = 2'd2;
    cyc(1);
    chk("load_rd_data", rd_data, mk(7'h33));
    chk("load_done_pulse", done, 0);

    // Keep: sends the committed bank, no commit
    run_keep("keep", mk(7'h11), mk(7'h22), mk(7'h33), mk(7'h44));
    chk("keep_rd_data", rd_data, mk(7'h33));

    // Early input: first word arrives with the shift, commit right after last send
    ov_cnt = 0;
    push(1'b1, mk(7'h11)); push(1'b1, mk(7'h22)); push(1'b1, mk(7'h33)); push(1'b1, mk(7'h44));
    exchange_shift = 1'b1; in_valid = 1'b1; in_data = mk(7'h2A);
    cyc(1);
    exchange_shift = 1'b0; in_data = mk(7'h05); cyc(1);
    in_data = mk(7'h06); cyc(1);
    in_data = mk(7'h07); cyc(1);
    in_valid = 1'b0;
    cyc(1);
    chk("early_commit_out_valid", out_valid, 0);
    chk("early_commit_busy", busy, 1);
    chk("early_commit_done", done, 0);
    cyc(1);
    chk("early_done", done, 1);
    chk("early_rd_old_bank", rd_data, mk(7'h33));
    cyc(1);
    chk("early_rd_new_bank", rd_data, mk(7'h06));
    chk("early_ov_cnt", ov_cnt, 4);
    run_keep("early_keep", mk(7'h2A), mk(7'h05), mk(7'h06), mk(7'h07));

    // Overrun: fifth word dropped and flagged
    ov_cnt = 0;
    push(1'b1, mk(7'h2A)); push(1'b1, mk(7'h05)); push(1'b1, mk(7'h06)); push(1'b1, mk(7'h07));
    exchange_shift = 1'b1;
    cyc(1);
    exchange_shift = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = mk(7'(8'h51 + i));
      if (i == 4) chk("ovr_flag_before", err_overrun, 0);
      cyc(1);
    end
    in_valid = 1'b0;
    chk("ovr_flag", err_overrun, 1);
    chk("ovr_commit_busy", busy, 1);
    cyc(1);
    chk("ovr_done", done, 1);
    rd_addr = 2'd3;
    cyc(1);
    chk("ovr_rd_data", rd_data, mk(7'h54));
    run_keep("ovr_keep", mk(7'h51), mk(7'h52), mk(7'h53), mk(7'h54));

    // Collision: second shift mid-send is ignored but flagged
    ov_cnt = 0;
    push(1'b1, mk(7'h51)); push(1'b1, mk(7'h52)); push(1'b1, mk(7'h53)); push(1'b1, mk(7'h54));
    exchange_shift = 1'b1; exchange_keep = 1'b1;
    cyc(1);
    exchange_shift = 1'b0; exchange_keep = 1'b0;
    cyc(1);
    exchange_shift = 1'b1;
    chk("col_flag_before", err_collision, 0);
    cyc(1);
    exchange_shift = 1'b0;
    chk("col_flag", err_collision, 1);
    cyc(2);
    chk("col_done", done, 1);
    cyc(1);
    chk("col_idle_out_valid", out_valid, 0);
    chk("col_idle_busy", busy, 0);
    chk("col_ov_cnt", ov_cnt, 4);
    chk("col_overrun_sticky", err_overrun, 1);

    // Reset mid-send: abort, flags clear, next exchange sends bank 0
    ov_cnt = 0;
    done_snap = done_cnt;
    push(1'b1, mk(7'h51));
    exchange_shift = 1'b1;
    cyc(1);
    exchange_shift = 1'b0;
    cyc(1);
    reset = 1'b0;
    #1;
    chk("rmid_out_valid", out_valid, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_err_overrun", err_overrun, 0);
    chk("rmid_err_collision", err_collision, 0);
    cyc(2);
    reset = 1'b1;
    cyc(2);
    chk("rmid_no_done", done_cnt, done_snap);
    chk("rmid_ov_cnt", ov_cnt, 1);
    chk("rmid_idle_busy", busy, 0);
    run_keep("rmid_keep", mk(7'h2A), mk(7'h05), mk(7'h06), mk(7'h07));

    cyc(2);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
